// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; retires the head on
// resolution, trains the predictor, squashes younger entries on mispredict.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pred_valid,
    output logic                     pred_ready,
    input  logic                     pred_taken,
    input  logic [IDX_W-1:0]         pred_idx,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_valid,
    output logic [IDX_W-1:0]         upd_idx,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow_err,
    output logic [CNT_W-1:0]         resolved_cnt,
    output logic [CNT_W-1:0]         mispred_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] ent_taken_q;
    logic [IDX_W-1:0] ent_idx_q [DEPTH];

    logic             upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_taken_q, upd_taken_d;
    logic             mispredict_q, mispredict_d;
    logic             underflow_q, underflow_d;
    logic [CNT_W-1:0] resolved_q, resolved_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    logic             empty;
    logic             full;
    logic             enq;
    logic             ret;
    logic             mis;
    logic             head_taken;
    logic [IDX_W-1:0] head_idx;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign pred_ready = !full;
    assign enq        = pred_valid && !full;
    assign ret        = res_valid && !empty;
    assign head_taken = ent_taken_q[rd_ptr_q];
    assign head_idx   = ent_idx_q[rd_ptr_q];
    assign mis        = ret && (head_taken != res_taken);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (ret) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case (1'b1)
            (enq && !ret): count_d = count_q + CW'(1);
            (ret && !enq): count_d = count_q - CW'(1);
            default:       count_d = count_q;
        endcase
        // A same-edge enqueue is younger than the bad branch, so it goes too.
        if (mis) begin
            rd_ptr_d = wr_ptr_d;
            count_d  = '0;
        end
    end

    always_comb begin
        upd_valid_d  = ret;
        mispredict_d = mis;
        upd_idx_d    = upd_idx_q;
        upd_taken_d  = upd_taken_q;
        if (ret) begin
            upd_idx_d   = head_idx;
            upd_taken_d = res_taken;
        end
        underflow_d = underflow_q || (res_valid && empty);
    end

    always_comb begin
        resolved_d = resolved_q;
        mispred_d  = mispred_q;
        if (ret && (resolved_q != '1)) begin
            resolved_d = resolved_q + CNT_W'(1);
        end
        if (mis && (mispred_q != '1)) begin
            mispred_d = mispred_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ent_taken_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_idx_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (enq) begin
                ent_taken_q[wr_ptr_q] <= pred_taken;
                ent_idx_q[wr_ptr_q]   <= pred_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_q  <= 1'b0;
            upd_idx_q    <= '0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            underflow_q  <= 1'b0;
            resolved_q   <= '0;
            mispred_q    <= '0;
        end else begin
            upd_valid_q  <= upd_valid_d;
            upd_idx_q    <= upd_idx_d;
            upd_taken_q  <= upd_taken_d;
            mispredict_q <= mispredict_d;
            underflow_q  <= underflow_d;
            resolved_q   <= resolved_d;
            mispred_q    <= mispred_d;
        end
    end

    assign upd_valid     = upd_valid_q;
    assign upd_idx       = upd_idx_q;
    assign upd_taken     = upd_taken_q;
    assign mispredict    = mispredict_q;
    assign count         = count_q;
    assign underflow_err = underflow_q;
    assign resolved_cnt  = resolved_q;
    assign mispred_cnt   = mispred_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomised and directed bench for branch_resolve_queue against a
// queue-based reference model; a CNT_W=4 copy exercises saturation.
module tb_branch_resolve_queue;

    logic       clk;
    logic       rst_n;
    logic       pred_valid;
    logic       pred_taken;
    logic [5:0] pred_idx;
    logic       res_valid;
    logic       res_taken;

    logic       pred_ready;
    logic       upd_valid;
    logic [5:0] upd_idx;
    logic       upd_taken;
    logic       mispredict;
    logic [3:0] count;
    logic       underflow_err;
    logic [15:0] resolved_cnt;
    logic [15:0] mispred_cnt;

    logic       s_pred_ready;
    logic       s_upd_valid;
    logic [5:0] s_upd_idx;
    logic       s_upd_taken;
    logic       s_mispredict;
    logic [3:0] s_count;
    logic       s_underflow_err;
    logic [3:0] s_resolved_cnt;
    logic [3:0] s_mispred_cnt;

    branch_resolve_queue #(.DEPTH(8), .IDX_W(6), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_ready(pred_ready),
        .pred_taken(pred_taken), .pred_idx(pred_idx),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_taken(upd_taken), .mispredict(mispredict),
        .count(count), .underflow_err(underflow_err),
        .resolved_cnt(resolved_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_resolve_queue #(.DEPTH(8), .IDX_W(6), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_ready(s_pred_ready),
        .pred_taken(pred_taken), .pred_idx(pred_idx),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(s_upd_valid), .upd_idx(s_upd_idx),
        .upd_taken(s_upd_taken), .mispredict(s_mispredict),
        .count(s_count), .underflow_err(s_underflow_err),
        .resolved_cnt(s_resolved_cnt), .mispred_cnt(s_mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       t;
        logic [5:0] idx;
    } ent_t;

    ent_t mq[$];
    bit       m_uv;
    bit       m_mis;
    bit       m_ut;
    bit [5:0] m_idx;
    bit       m_uf;
    int       m_res;
    int       m_mp;
    int       s_res;
    int       s_mp;

    int n_cmp;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_uv  = 0;
        m_mis = 0;
        m_ut  = 0;
        m_idx = '0;
        m_uf  = 0;
        m_res = 0;
        m_mp  = 0;
        s_res = 0;
        s_mp  = 0;
    endtask

    task automatic check_state();
        chk("count", count, mq.size());
        chk("upd_valid", upd_valid, m_uv);
        chk("mispredict", mispredict, m_mis);
        chk("upd_idx", upd_idx, m_idx);
        chk("upd_taken", upd_taken, m_ut);
        chk("underflow", underflow_err, m_uf);
        chk("resolved", resolved_cnt, m_res);
        chk("mispred", mispred_cnt, m_mp);
        chk("s_resolved", s_resolved_cnt, s_res);
        chk("s_mispred", s_mispred_cnt, s_mp);
        chk("s_count", s_count, mq.size());
    endtask

    // Asserts reset off-edge and checks outputs clear before any clock.
    task automatic do_reset();
        rst_n      = 1'b0;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        #2;
        model_clear();
        check_state();
        chk("rst_ready", pred_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit pv, input bit pt, input int idx,
                        input bit rv, input bit rt);
        bit   rdy;
        bit   en;
        bit   fire;
        bit   mis;
        ent_t h;
        @(negedge clk);
        pred_valid = pv;
        pred_taken = pt;
        pred_idx   = idx[5:0];
        res_valid  = rv;
        res_taken  = rt;
        rdy  = (mq.size() != 8);
        chk("pred_ready", pred_ready, rdy);
        en   = pv && rdy;
        fire = rv && (mq.size() != 0);
        mis  = 0;
        if (rv && mq.size() == 0) m_uf = 1;
        m_uv  = fire;
        m_mis = 0;
        if (fire) begin
            h     = mq.pop_front();
            m_idx = h.idx;
            m_ut  = rt;
            mis   = (h.t != rt);
            m_mis = mis;
            if (m_res < 65535) m_res++;
            if (s_res < 15) s_res++;
            if (mis && m_mp < 65535) m_mp++;
            if (mis && s_mp < 15) s_mp++;
        end
        if (en) begin
            h.t   = pt;
            h.idx = idx[5:0];
            mq.push_back(h);
        end
        if (mis) mq.delete();
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        pred_taken = 1'b0;
        pred_idx   = '0;
        res_taken  = 1'b0;
        do_reset();

        // two correct resolutions
        step(1, 1, 5, 0, 0);
        step(1, 0, 9, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("t1_idx5", upd_idx, 5);
        step(0, 0, 0, 1, 0);
        chk("t1_idx9", upd_idx, 9);
        chk("t1_mis", mispredict, 0);
        chk("t1_res", resolved_cnt, 2);
        idle();

        // fill, reject when full, retire, wrap
        for (int i = 0; i < 8; i++) step(1, 1, 10 + i, 0, 0);
        chk("t2_full", count, 8);
        chk("t2_ready", pred_ready, 0);
        step(1, 1, 30, 0, 0);
        chk("t2_noenq", count, 8);
        step(0, 0, 0, 1, 1);
        step(1, 1, 31, 0, 0);
        chk("t2_wrap", count, 8);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);
        chk("t2_lastidx", upd_idx, 31);
        idle();

        // mispredict squash
        step(1, 1, 3, 0, 0);
        step(1, 1, 4, 0, 0);
        step(1, 0, 6, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("t3_mis", mispredict, 1);
        chk("t3_idx", upd_idx, 3);
        chk("t3_cnt", count, 0);
        chk("t3_mpc", mispred_cnt, 1);
        step(0, 0, 0, 1, 1);
        chk("t3_nopulse", upd_valid, 0);

        // enqueue on the retiring edge
        step(1, 1, 1, 0, 0);
        step(1, 1, 2, 0, 0);
        step(1, 1, 20, 1, 0);
        chk("t4_drop", count, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 2, 0, 0);
        step(1, 0, 7, 1, 1);
        chk("t4_keep", count, 2);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);

        // underflow, then reset mid-stream
        step(0, 0, 0, 1, 1);
        chk("t5_uf", underflow_err, 1);
        idle();
        chk("t5_ufheld", underflow_err, 1);
        for (int i = 0; i < 5; i++) step(1, i[0], 40 + i, 0, 0);
        step(0, 0, 0, 1, 1);
        step(1, 1, 50, 0, 0);
        #2;
        do_reset();

        // saturation of the narrow counters
        for (int i = 0; i < 20; i++) begin
            step(1, 1, i, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        chk("t6_smp", s_mispred_cnt, 15);
        chk("t6_sres", s_resolved_cnt, 15);
        chk("t6_mp", mispred_cnt, 20);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, 1'($urandom),
                 int'($urandom_range(0, 63)),
                 $urandom_range(0, 99) < 40, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
